hw_sig_pio: RTL and testbench



---
 rtl/hw_sig_pio_pkg.sv | 30 +++
 rtl/hw_sig_sync.sv | 43 ++++
 rtl/hw_sig_pio.sv | 200 ++++++++++++++++++++
 tb/tb_hw_sig_pio.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hw_sig_pio_pkg.sv
// -----------------------------------------------------------------------------
// hw_sig_pio_pkg
//   Shared constants and types for the hw_sig_pio Avalon-MM PIO slave:
//   register word addresses, the edge-detect selector and the pulse FSM states.
// -----------------------------------------------------------------------------
package hw_sig_pio_pkg;

    localparam int REG_W = 32;

    // Avalon word addresses (address 7 is reserved: reads 0, writes ignored)
    localparam logic [2:0] ADDR_DATA_OUT = 3'd0;
    localparam logic [2:0] ADDR_DATA_IN  = 3'd1;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
    localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
    localparam logic [2:0] ADDR_OUT_SET  = 3'd4;
    localparam logic [2:0] ADDR_OUT_CLR  = 3'd5;
    localparam logic [2:0] ADDR_PULSE    = 3'd6;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_ANY  = 2'd2
    } edge_type_e;

    typedef enum logic {
        P_IDLE   = 1'b0,
        P_ACTIVE = 1'b1
    } pulse_state_e;

endpackage : hw_sig_pio_pkg

// File: rtl/hw_sig_sync.sv
// -----------------------------------------------------------------------------
// hw_sig_sync
//   Multi-flop bit-vector synchroniser with asynchronous active-low reset.
//   Each bit is synchronised independently; no cross-bit coherency is implied.
// Ports:
//   clk      in   clock of the destination domain
//   reset_n  in   async active-low reset, clears every stage
//   d        in   WIDTH asynchronous inputs
//   q        out  WIDTH synchronised outputs (STAGES cycles of latency)
// -----------------------------------------------------------------------------
module hw_sig_sync #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] sync_q;
    logic [STAGES-1:0][WIDTH-1:0] sync_d;

    always_comb begin
        sync_d[0] = d;
        for (int i = 1; i < STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples the previous stage's old value on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule : hw_sig_sync

// File: rtl/hw_sig_pio.sv
// -----------------------------------------------------------------------------
// hw_sig_pio
//   Avalon-MM PIO slave between Nios II software and the RSA datapath.
//   Output register with atomic set/clear, self-timing pulse strobes, and a
//   synchronised input port with edge capture and a maskable level interrupt.
// Ports:
//   clk, reset_n       clock and async active-low reset
//   address[2:0]       word address (see hw_sig_pio_pkg)
//   chipselect         slave select
//   write_n            active-low write strobe
//   writedata[31:0]    write data (only the low OUT_W / IN_W bits are used)
//   readdata[31:0]     combinational read data, zero-extended, 0 when deselected
//   in_port[IN_W]      asynchronous status inputs from hardware
//   out_port[OUT_W]    level outputs to hardware
//   pulse_port[OUT_W]  timed strobes to hardware
//   irq                registered level interrupt, active high
// -----------------------------------------------------------------------------
module hw_sig_pio
    import hw_sig_pio_pkg::*;
#(
    parameter int          OUT_W        = 4,
    parameter int          IN_W         = 4,
    parameter int          SYNC_STAGES  = 2,
    parameter int          EDGE_TYPE    = 0,
    parameter int          PULSE_CYCLES = 1,
    parameter logic [31:0] OUT_RESET    = 32'd0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [IN_W-1:0]  in_port,
    output logic [OUT_W-1:0] out_port,
    output logic [OUT_W-1:0] pulse_port,
    output logic             irq
);

    localparam edge_type_e      EDGE_SEL   = edge_type_e'(EDGE_TYPE[1:0]);
    localparam logic [7:0]      PULSE_LOAD = 8'(PULSE_CYCLES - 1);
    localparam logic [OUT_W-1:0] OUT_INIT  = OUT_RESET[OUT_W-1:0];

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic             wr_en;
    logic [OUT_W-1:0] wd_out;
    logic [IN_W-1:0]  wd_in;
    logic             unused_wd;

    assign wr_en     = chipselect && !write_n;
    assign wd_out    = writedata[OUT_W-1:0];
    assign wd_in     = writedata[IN_W-1:0];
    assign unused_wd = ^writedata;

    // ------------------------------------------------------------------
    // Input path: synchroniser, one-cycle history, edge detect
    // ------------------------------------------------------------------
    logic [IN_W-1:0] sync_s;
    logic [IN_W-1:0] prev_q,  prev_d;
    logic [IN_W-1:0] edge_det;

    hw_sig_sync #(
        .WIDTH  (IN_W),
        .STAGES (SYNC_STAGES)
    ) u_in_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (in_port),
        .q       (sync_s)
    );

    always_comb begin
        unique case (EDGE_SEL)
            EDGE_RISE: edge_det = sync_s & ~prev_q;
            EDGE_FALL: edge_det = ~sync_s & prev_q;
            default:   edge_det = sync_s ^ prev_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Register file next-state
    // ------------------------------------------------------------------
    logic [OUT_W-1:0] data_out_q, data_out_d;
    logic [IN_W-1:0]  irq_mask_q, irq_mask_d;
    logic [IN_W-1:0]  edge_cap_q, edge_cap_d;
    logic [IN_W-1:0]  w1c;
    logic             irq_q,      irq_d;

    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        data_out_d = data_out_q;
        irq_mask_d = irq_mask_q;
        w1c        = '0;
        prev_d     = sync_s;

        if (wr_en) begin
            unique case (address)
                ADDR_DATA_OUT: data_out_d = wd_out;
                ADDR_OUT_SET:  data_out_d = data_out_q | wd_out;
                ADDR_OUT_CLR:  data_out_d = data_out_q & ~wd_out;
                ADDR_IRQ_MASK: irq_mask_d = wd_in;
                ADDR_EDGE_CAP: w1c        = wd_in;
                default:       ;
            endcase
        end

        // A new edge on a bit being cleared in the same cycle keeps it set.
        edge_cap_d = (edge_cap_q & ~w1c) | edge_det;

        // Built from the registered capture, so irq trails cap by one cycle.
        irq_d = |(edge_cap_q & irq_mask_q);
    end

    // ------------------------------------------------------------------
    // Pulse machine
    // ------------------------------------------------------------------
    pulse_state_e     state_q,     state_d;
    logic [OUT_W-1:0] pulse_reg_q, pulse_reg_d;
    logic [7:0]       cnt_q,       cnt_d;
    logic             pulse_wr;

    assign pulse_wr = wr_en && (address == ADDR_PULSE);

    always_comb begin
        state_d     = state_q;
        pulse_reg_d = pulse_reg_q;
        cnt_d       = cnt_q;

        if (state_q == P_ACTIVE) begin
            if (cnt_q == 8'd0) begin
                state_d     = P_IDLE;
                pulse_reg_d = '0;
            end else begin
                cnt_d = cnt_q - 8'd1;
            end
        end

        // A write overrides the countdown: nonzero retriggers, zero aborts.
        if (pulse_wr) begin
            if (wd_out != '0) begin
                state_d     = P_ACTIVE;
                pulse_reg_d = wd_out;
                cnt_d       = PULSE_LOAD;
            end else begin
                state_d     = P_IDLE;
                pulse_reg_d = '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out_q  <= OUT_INIT;
            irq_mask_q  <= '0;
            edge_cap_q  <= '0;
            prev_q      <= '0;
            irq_q       <= 1'b0;
            state_q     <= P_IDLE;
            pulse_reg_q <= '0;
            cnt_q       <= '0;
        end else begin
            data_out_q  <= data_out_d;
            irq_mask_q  <= irq_mask_d;
            edge_cap_q  <= edge_cap_d;
            prev_q      <= prev_d;
            irq_q       <= irq_d;
            state_q     <= state_d;
            pulse_reg_q <= pulse_reg_d;
            cnt_q       <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign out_port   = data_out_q;
    assign pulse_port = (state_q == P_ACTIVE) ? pulse_reg_q : '0;
    assign irq        = irq_q;

    always_comb begin
        readdata = '0;
        if (chipselect) begin
            unique case (address)
                ADDR_DATA_OUT: readdata = REG_W'(data_out_q);
                ADDR_DATA_IN:  readdata = REG_W'(sync_s);
                ADDR_IRQ_MASK: readdata = REG_W'(irq_mask_q);
                ADDR_EDGE_CAP: readdata = REG_W'(edge_cap_q);
                default:       readdata = '0;
            endcase
        end
    end

endmodule : hw_sig_pio

// File: tb/tb_hw_sig_pio.sv
// -----------------------------------------------------------------------------
// tb_hw_sig_pio
//   Directed self-checking bench for hw_sig_pio with OUT_W=4, IN_W=4,
//   SYNC_STAGES=2, EDGE_TYPE=rising, PULSE_CYCLES=3, OUT_RESET=0x5.
//   Inputs change on the falling edge; outputs are sampled there as well.
// -----------------------------------------------------------------------------
module tb_hw_sig_pio;

    localparam int          OUT_W        = 4;
    localparam int          IN_W         = 4;
    localparam int          SYNC_STAGES  = 2;
    localparam int          PULSE_CYCLES = 3;
    localparam logic [31:0] OUT_RESET    = 32'h5;

    logic             clk;
    logic             reset_n;
    logic [2:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [31:0]      writedata;
    logic [31:0]      readdata;
    logic [IN_W-1:0]  in_port;
    logic [OUT_W-1:0] out_port;
    logic [OUT_W-1:0] pulse_port;
    logic             irq;

    int checks;
    int errors;

    hw_sig_pio #(
        .OUT_W        (OUT_W),
        .IN_W         (IN_W),
        .SYNC_STAGES  (SYNC_STAGES),
        .EDGE_TYPE    (0),
        .PULSE_CYCLES (PULSE_CYCLES),
        .OUT_RESET    (OUT_RESET)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .out_port   (out_port),
        .pulse_port (pulse_port),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; the write lands on the following rising edge
    // and the task returns at the next falling edge.
    task automatic bus_write(input logic [2:0] addr, input logic [31:0] data);
        address    = addr;
        writedata  = data;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic bus_read(input logic [2:0] addr, output logic [31:0] data);
        address    = addr;
        chipselect = 1'b1;
        write_n    = 1'b1;
        #1;
        data       = readdata;
        chipselect = 1'b0;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    logic [31:0] rd;

    initial begin
        checks     = 0;
        errors     = 0;
        reset_n    = 1'b0;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = '0;

        // ---------------- reset state ----------------
        cycles(3);
        check("rst_out_port",   32'(out_port),   32'h5);
        check("rst_pulse_port", 32'(pulse_port), 32'h0);
        check("rst_irq",        32'(irq),        32'h0);
        reset_n = 1'b1;
        cycles(1);
        for (int a = 0; a < 8; a++) begin
            bus_read(3'(a), rd);
            check($sformatf("rst_read_addr%0d", a), rd, (a == 0) ? 32'h5 : 32'h0);
        end
        bus_read(3'd0, rd);
        address = 3'd0;
        #1;
        check("deselected_readdata", readdata, 32'h0);

        // ---------------- output register ----------------
        cycles(1);
        bus_write(3'd0, 32'hFFFF_FFFA);
        check("data_out_write", 32'(out_port), 32'hA);
        bus_write(3'd4, 32'h5);
        check("out_set", 32'(out_port), 32'hF);
        bus_write(3'd5, 32'h3);
        check("out_clr", 32'(out_port), 32'hC);
        bus_read(3'd0, rd);
        check("data_out_read", rd, 32'hC);
        cycles(1);
        bus_write(3'd7, 32'hF);
        bus_write(3'd1, 32'hF);
        check("ignored_writes_out", 32'(out_port), 32'hC);
        bus_read(3'd1, rd);
        check("data_in_ro", rd, 32'h0);

        // ---------------- edge capture and irq ----------------
        cycles(1);
        bus_write(3'd2, 32'h1);
        bus_read(3'd2, rd);
        check("irq_mask_read", rd, 32'h1);
        cycles(1);
        in_port = 4'h1;                 // change before edge E1
        cycles(1);                      // after E1
        bus_read(3'd3, rd);
        check("cap_e1", rd, 32'h0);
        cycles(1);                      // after E2
        bus_read(3'd3, rd);
        check("cap_e2", rd, 32'h0);
        cycles(1);                      // after E3 = SYNC_STAGES+1
        bus_read(3'd3, rd);
        check("cap_e3", rd, 32'h1);
        check("irq_e3", 32'(irq), 32'h0);
        cycles(1);                      // after E4
        check("irq_e4", 32'(irq), 32'h1);
        bus_read(3'd1, rd);
        check("data_in_sync", rd, 32'h1);
        cycles(1);
        bus_write(3'd3, 32'h1);         // W1C
        bus_read(3'd3, rd);
        check("cap_cleared", rd, 32'h0);
        check("irq_after_w1c_edge", 32'(irq), 32'h1);
        cycles(1);
        check("irq_falls", 32'(irq), 32'h0);
        in_port = 4'h0;                 // falling edge must not capture
        cycles(5);
        bus_read(3'd3, rd);
        check("cap_no_fall", rd, 32'h0);
        check("irq_no_fall", 32'(irq), 32'h0);

        // ---------------- W1C colliding with a new edge ----------------
        cycles(1);
        in_port = 4'h1;
        cycles(5);
        check("irq_before_collide", 32'(irq), 32'h1);
        in_port = 4'h0;
        cycles(4);
        in_port = 4'h1;                 // edge term high after E2
        cycles(2);
        bus_write(3'd3, 32'h1);         // W1C lands on E3 with the edge
        bus_read(3'd3, rd);
        check("cap_set_wins", rd, 32'h1);
        check("irq_set_wins", 32'(irq), 32'h1);
        cycles(1);
        check("irq_set_wins_next", 32'(irq), 32'h1);

        // ---------------- pulse: plain 3-cycle strobe ----------------
        check("pulse_idle", 32'(pulse_port), 32'h0);
        bus_write(3'd6, 32'h2);
        check("pulse_c1", 32'(pulse_port), 32'h2);
        cycles(1);
        check("pulse_c2", 32'(pulse_port), 32'h2);
        cycles(1);
        check("pulse_c3", 32'(pulse_port), 32'h2);
        cycles(1);
        check("pulse_end", 32'(pulse_port), 32'h0);
        cycles(1);
        check("pulse_end2", 32'(pulse_port), 32'h0);

        // ---------------- pulse: retrigger in cycle 2 ----------------
        bus_write(3'd6, 32'h2);
        check("retrig_c1", 32'(pulse_port), 32'h2);
        cycles(1);
        check("retrig_c2", 32'(pulse_port), 32'h2);
        bus_write(3'd6, 32'h4);
        check("retrig_n1", 32'(pulse_port), 32'h4);
        cycles(1);
        check("retrig_n2", 32'(pulse_port), 32'h4);
        cycles(1);
        check("retrig_n3", 32'(pulse_port), 32'h4);
        cycles(1);
        check("retrig_end", 32'(pulse_port), 32'h0);

        // ---------------- pulse: abort ----------------
        bus_write(3'd6, 32'h1);
        check("abort_c1", 32'(pulse_port), 32'h1);
        bus_write(3'd6, 32'h0);
        check("abort_now", 32'(pulse_port), 32'h0);
        cycles(1);
        check("abort_stays", 32'(pulse_port), 32'h0);

        // ---------------- async reset mid-pulse ----------------
        bus_write(3'd6, 32'h8);
        check("pre_rst_pulse", 32'(pulse_port), 32'h8);
        bus_read(3'd3, rd);
        check("pre_rst_cap", rd, 32'h1);
        check("pre_rst_irq", 32'(irq), 32'h1);
        #2;
        in_port = 4'h0;
        reset_n = 1'b0;                 // no clock edge in this window
        #1;
        check("arst_pulse", 32'(pulse_port), 32'h0);
        check("arst_irq",   32'(irq),        32'h0);
        check("arst_out",   32'(out_port),   32'h5);
        bus_read(3'd3, rd);
        check("arst_cap", rd, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        cycles(5);
        check("post_rst_pulse", 32'(pulse_port), 32'h0);
        check("post_rst_irq",   32'(irq),        32'h0);
        bus_read(3'd3, rd);
        check("post_rst_cap", rd, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_hw_sig_pio
